// File: rtl/anton_mac_seq_if.sv
// Command/readout bus of the anton_mac_seq multiply-accumulate core.
interface anton_mac_seq_if #(
  parameter int unsigned DIN_W  = 4,
  parameter int unsigned DOUT_W = 8
);
  logic [1:0]        cmd;
  logic              rd;
  logic [DIN_W-1:0]  din;
  logic [DOUT_W-1:0] dout;
  logic              busy;

  modport master (output cmd, output rd, output din, input dout, input busy);
  modport slave  (input cmd, input rd, input din, output dout, output busy);
endinterface

// File: rtl/anton_mac_seq.sv
// anton_mac_seq: sequential multiply-accumulate core.
// Operands are shifted in DIN_W bits at a time, multiplied by an OP_W-cycle
// shift-add engine, and the guarded accumulator is read out through a
// rotating DOUT_W-bit window.
// Optional feature: define MAC_SATURATE_EN to clamp overflowing MACs to all-ones.
module anton_mac_seq #(
  parameter int unsigned DIN_W   = 4,
  parameter int unsigned OP_W    = 8,
  parameter int unsigned GUARD_W = 8,
  parameter int unsigned DOUT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  anton_mac_seq_if.slave     bus
);

  localparam int unsigned ACC_W = 2*OP_W + GUARD_W;
  localparam int unsigned PRD_W = 2*OP_W;
  localparam int unsigned CNT_W = $clog2(OP_W+1);

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_MUL  = 2'b10;
  localparam logic [1:0] CMD_MAC  = 2'b11;

  typedef enum logic {S_IDLE, S_CALC} state_t;
  typedef enum logic {MODE_MUL, MODE_MAC} mode_t;

  state_t             state, state_d;
  mode_t              mode, mode_d;
  logic [PRD_W-1:0]   opr, opr_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [ACC_W-1:0]   acc_rot, acc_rot_d;
  logic [PRD_W-1:0]   mcand, mcand_d;
  logic [OP_W-1:0]    mplier, mplier_d;
  logic [PRD_W-1:0]   psum, psum_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               busy_q, busy_d;

  // Result path helpers for the final engine cycle
  logic [PRD_W-1:0]   psum_next;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   mac_res;

  assign bus.dout = acc_rot[DOUT_W-1:0];
  assign bus.busy = busy_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      mode    <= MODE_MUL;
      opr     <= '0;
      acc     <= '0;
      acc_rot <= '0;
      mcand   <= '0;
      mplier  <= '0;
      psum    <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      mode    <= mode_d;
      opr     <= opr_d;
      acc     <= acc_d;
      acc_rot <= acc_rot_d;
      mcand   <= mcand_d;
      mplier  <= mplier_d;
      psum    <= psum_d;
      cnt     <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, shift-add step and accumulator update
  always_comb begin
    state_d   = state;
    mode_d    = mode;
    opr_d     = opr;
    acc_d     = acc;
    acc_rot_d = acc_rot;
    mcand_d   = mcand;
    mplier_d  = mplier;
    psum_d    = psum;
    cnt_d     = cnt;
    busy_d    = busy_q;

    psum_next = mplier[0] ? (psum + mcand) : psum;
    prod_ext  = ACC_W'(psum_next);
    sum_ext   = {1'b0, acc} + {1'b0, prod_ext};
`ifdef MAC_SATURATE_EN
    mac_res   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    mac_res   = sum_ext[ACC_W-1:0];
`endif

    unique case (state)
      S_IDLE: begin
        if (bus.cmd == CMD_MUL || bus.cmd == CMD_MAC) begin
          // Start: rd is dropped in this cycle
          mcand_d  = {OP_W'(0), opr[PRD_W-1:OP_W]};
          mplier_d = opr[OP_W-1:0];
          mode_d   = (bus.cmd == CMD_MAC) ? MODE_MAC : MODE_MUL;
          psum_d   = '0;
          cnt_d    = CNT_W'(OP_W);
          state_d  = S_CALC;
          busy_d   = 1'b1;
        end else begin
          if (bus.cmd == CMD_LOAD) begin
            opr_d = {opr[PRD_W-DIN_W-1:0], bus.din};
          end
          if (bus.rd) begin
            acc_rot_d = {acc_rot[DOUT_W-1:0], acc_rot[ACC_W-1:DOUT_W]};
          end
        end
      end
      S_CALC: begin
        psum_d   = psum_next;
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        cnt_d    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          acc_d     = (mode == MODE_MAC) ? mac_res : prod_ext;
          acc_rot_d = acc_d;
          state_d   = S_IDLE;
          busy_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_anton_mac_seq.sv
// Self-checking bench for anton_mac_seq at default parameters.
module tb_anton_mac_seq;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] MUL  = 2'b10;
  localparam logic [1:0] MAC  = 2'b11;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [23:0] sb[$];

  anton_mac_seq_if #(.DIN_W(4), .DOUT_W(8)) bus ();

  anton_mac_seq #(.DIN_W(4), .OP_W(8), .GUARD_W(8), .DOUT_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  cmd;
    logic [23:0] exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    w = {a, b};
    for (int i = 3; i >= 0; i--) begin
      bus.cmd = LOAD;
      bus.din = w[i*4 +: 4];
      tick();
    end
    bus.cmd = HOLD;
  endtask

  task automatic start(input logic [1:0] c);
    bus.cmd = c;
    tick();
    bus.cmd = HOLD;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    if (bus.busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: busy still 0x%0h after %0d cycles, required 0x0", bus.busy, cycles);
    end
  endtask

  // Reads three chunks, leaving the window wrapped back to chunk 0
  task automatic read_acc(output logic [23:0] v);
    logic [7:0] c0, c1, c2;
    c0 = bus.dout;
    bus.rd = 1'b1;
    tick();
    c1 = bus.dout;
    tick();
    c2 = bus.dout;
    tick();
    bus.rd = 1'b0;
    check("rd_wrap", 32'(bus.dout), 32'(c0));
    v = {c2, c1, c0};
  endtask

  task automatic compare_sb(input string name, input logic [23:0] act);
    logic [23:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%0h with empty scoreboard, required an entry", name, act);
    end else begin
      e = sb.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                         input logic [23:0] exp_acc);
    int cy;
    logic [23:0] v;
    load_pair(a, b);
    sb.push_back(exp_acc);
    start(c);
    check("busy_start", 32'(bus.busy), 32'd1);
    wait_done(cy);
    check("busy_cycles", 32'(cy), 32'd8);
    check("dout_low", 32'(bus.dout), 32'(exp_acc[7:0]));
    read_acc(v);
    compare_sb("vec_acc", v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cy;
    logic [23:0] v;
    logic [23:0] exp_ovf;
    n_cmp = 0;
    n_bad = 0;
    bus.cmd = HOLD;
    bus.rd  = 1'b0;
    bus.din = 4'h0;
    rst_n   = 1'b0;
    #3;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_dout", 32'(bus.dout), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Basic multiply and readout with explicit chunk order
    load_pair(8'h12, 8'h34);
    start(MUL);
    wait_done(cy);
    check("basic_busy_cycles", 32'(cy), 32'd8);
    check("basic_dout0", 32'(bus.dout), 32'hA8);
    bus.rd = 1'b1;
    tick();
    check("basic_dout1", 32'(bus.dout), 32'h03);
    tick();
    check("basic_dout2", 32'(bus.dout), 32'h00);
    tick();
    bus.rd = 1'b0;
    check("basic_dout_wrap", 32'(bus.dout), 32'hA8);

    // Table: running accumulator continues from 0x0003A8
    vecs[0] = '{8'h00, 8'hFF, MUL, 24'h000000};
    vecs[1] = '{8'hFF, 8'hFF, MUL, 24'h00FE01};
    vecs[2] = '{8'h12, 8'h34, MAC, 24'h0101A9};
    vecs[3] = '{8'h80, 8'h02, MAC, 24'h0102A9};
    vecs[4] = '{8'h01, 8'h01, MUL, 24'h000001};
    vecs[5] = '{8'h0F, 8'h10, MAC, 24'h0000F1};
    vecs[6] = '{8'h12, 8'h34, MUL, 24'h0003A8};
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].exp_acc);
    end

    // LOAD and rd during CALC are ignored
    start(MUL);
    bus.cmd = LOAD;
    bus.din = 4'hF;
    bus.rd  = 1'b1;
    tick();
    tick();
    check("calc_dout_hold", 32'(bus.dout), 32'hA8);
    tick();
    bus.cmd = HOLD;
    bus.rd  = 1'b0;
    wait_done(cy);
    check("calc_ign_cycles", 32'(cy), 32'd5);
    sb.push_back(24'h0003A8);
    read_acc(v);
    compare_sb("calc_ign_acc", v);
    // opr must still hold 0x12/0x34
    sb.push_back(24'h0003A8);
    start(MUL);
    wait_done(cy);
    read_acc(v);
    compare_sb("calc_opr_kept", v);

    // Asynchronous reset mid-CALC
    load_pair(8'h55, 8'h77);
    start(MUL);
    tick();
    tick();
    tick();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_dout", 32'(bus.dout), 32'd0);
    #7;
    rst_n = 1'b1;
    tick();
    read_acc(v);
    check("midreset_acc", 32'(v), 32'd0);
    run_vec(8'h02, 8'h03, MUL, 24'h000006);

    // Held MAC retriggers on the first IDLE edge
    do_reset();
    load_pair(8'h02, 8'h03);
    bus.cmd = MAC;
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("hold_first_busy", 32'(bus.busy), 32'd0);
    check("hold_first_dout", 32'(bus.dout), 32'h06);
    tick();
    bus.cmd = HOLD;
    check("hold_restart_busy", 32'(bus.busy), 32'd1);
    wait_done(cy);
    check("hold_second_cycles", 32'(cy), 32'd8);
    check("hold_second_dout", 32'(bus.dout), 32'h0C);
    tick();
    tick();
    check("hold_no_third", 32'(bus.busy), 32'd0);

    // 256 MACs of 0xFF*0xFF from reset
    do_reset();
    load_pair(8'hFF, 8'hFF);
    sb.push_back(24'hFE0100);
    for (int i = 0; i < 256; i++) begin
      start(MAC);
      wait_done(cy);
    end
    read_acc(v);
    compare_sb("mac256_acc", v);

    // Three more MACs overflow the accumulator
`ifdef MAC_SATURATE_EN
    exp_ovf = 24'hFFFFFF;
`else
    exp_ovf = 24'h00FB03;
`endif
    sb.push_back(exp_ovf);
    for (int i = 0; i < 3; i++) begin
      start(MAC);
      wait_done(cy);
    end
    read_acc(v);
    compare_sb("mac_overflow_acc", v);

    // MUL after overflow is unaffected by saturation
    run_vec(8'hFF, 8'hFF, MUL, 24'h00FE01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anton_mac_seq.md
# anton_mac_seq

Parametrised sequential multiply-accumulate unit that extends the nibble-shift product block.
- Operands are shifted in DIN_W bits per cycle.
- The product is formed by an OP_W-cycle shift-add engine instead of a single-cycle multiplier.
- The result either replaces or accumulates into a guarded accumulator.
- The accumulator is read out DOUT_W bits at a time through a rotating window.
- Sits behind the chip's 8-bit io_in/io_out wrapper as the arithmetic core.

## Interface
- DIN_W, 4: input chunk width; OP_W must be a multiple of DIN_W.
- OP_W, 8: width of each unsigned operand.
- GUARD_W, 8: accumulator guard bits; ACC_W = 2*OP_W + GUARD_W.
- DOUT_W, 8: readout width; ACC_W must be a multiple of DOUT_W.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  2  command: 00 HOLD, 01 LOAD, 10 MUL, 11 MAC; sampled on the clk rising edge.
- rd  in  1  read-advance strobe; sampled on the clk rising edge.
- din  in  DIN_W  operand chunk, MSB chunk first.
- dout  out  DOUT_W  current readout window, acc_rot[DOUT_W-1:0].
- busy  out  1  high while the multiply engine runs.

## Operation
Registers:
- opr: 2*OP_W bits, the operand shift chain; a = opr[2*OP_W-1:OP_W], b = opr[OP_W-1:0].
- acc: ACC_W bits.
- acc_rot: ACC_W bits, the readout copy.
- Working multiplicand, multiplier and partial sum; bit counter of clog2(OP_W+1) bits.
- state: IDLE or CALC.
- mode: MUL or MAC.

IDLE behaviour:
- HOLD: nothing changes.
- LOAD: opr <= {opr[2*OP_W-DIN_W-1:0], din}.
- MUL/MAC:
  - Latch a, b and mode; clear the partial sum; counter = OP_W; go to CALC.
  - opr is unchanged.
- rd=1: acc_rot rotates right by DOUT_W, circularly.
  - After ACC_W/DOUT_W strobes it wraps to the first chunk.
  - rd is independent of LOAD and may coincide with it.
  - rd is ignored in the cycle MUL/MAC is accepted.

CALC behaviour:
- Each cycle: if the multiplier LSB is 1, add the multiplicand to the partial sum; shift the multiplicand left 1 and the multiplier right 1; decrement the counter.
- On the edge where the counter goes 1->0:
  - acc <= product (MUL) or acc + product (MAC), modulo 2^ACC_W.
  - acc_rot <= the same value, so the window restarts at the LS chunk.
  - State returns to IDLE.
- All cmd and rd inputs are ignored during CALC; LOAD does not alter opr.

General rules:
- All arithmetic is unsigned.
- The product is zero-extended to ACC_W.
- cmd is level-sensitive. MUL/MAC still asserted on the first IDLE cycle starts another operation, so the driver returns cmd to HOLD.

Reset (reset=0, asynchronous) clears:
- opr, acc, acc_rot and the working registers to 0.
- state to IDLE.
- busy and dout to 0.

Reset asserted mid-CALC aborts the operation and leaves acc = 0.

## Timing
- LOAD: opr updates on the same edge; a full operand pair takes 2*OP_W/DIN_W cycles (4 by default).
- MUL/MAC accepted on edge E: busy is high after E through edge E+OP_W, where it falls.
- acc, acc_rot and dout show the result after edge E+OP_W, i.e. OP_W cycles latency.
- The next command is accepted on edge E+OP_W+1.
- rd: dout shows the next chunk after the sampling edge, one cycle latency.
- busy and dout are registered, with no combinational path from the inputs.

## Configuration
- MAC_SATURATE_EN defined:
  - A MAC whose true sum exceeds 2^ACC_W-1 sets acc to all-ones (2^ACC_W-1).
  - MUL cannot overflow and is unaffected.
- MAC_SATURATE_EN undefined: a MAC wraps modulo 2^ACC_W.

## Test plan
Defaults throughout (DIN_W=4, OP_W=8, GUARD_W=8, ACC_W=24, DOUT_W=8).
- Basic multiply and readout:
  - Stimulus: LOAD nibbles 1,2,3,4, then MUL for one cycle.
  - busy is high for exactly 8 cycles; acc=0x0003A8; dout=0xA8.
  - rd strobes give 0x03, 0x00, then 0xA8 (wrap).
- MAC accumulation:
  - Stimulus: load a=0xFF, b=0xFF, issue 256 MACs from reset.
  - Expect acc=0xFE0100.
- MAC overflow:
  - Stimulus: 3 further MACs on top of the previous state.
  - Expect 0x00FB03 without MAC_SATURATE_EN; 0xFFFFFF with it.
- Commands during CALC:
  - Stimulus: LOAD nibble 0xF and rd during CALC.
  - opr unchanged, dout unchanged, and the result is still 0x0003A8.
- Reset mid-operation:
  - Stimulus: reset low asynchronously 3 cycles into CALC, between clock edges.
  - busy=0, dout=0, acc=0 immediately.
  - After release, LOAD 0,2,0,3 then MUL gives 0x000006.
- Held cmd retrigger:
  - Stimulus: hold MAC for 9 cycles with a=2, b=3, acc starting at 0.
  - The operation restarts on the first IDLE edge; acc reaches 6, then 12 after the second completion.
